mem_access_unit: RTL and testbench

//  MEM stage plus MEM/WB pipeline register. Takes a load/store (or ALU result) from EX/MEM, drives the data RAM

---
 rtl/mem_access_unit.sv | 163 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM pipeline stage plus the MEM/WB pipeline register.
//
// A load or store arriving from EX/MEM drives the data RAM request in the same cycle. The request
// carries byte enables, a word-aligned address and store data replicated across all four lanes.
// While the RAM has not accepted the request, the stage stalls the pipeline. A request that waits
// TIMEOUT_CYCLES stalled cycles is aborted and reported as a bus error. An op that is illegal
// (bad size code or misaligned word) never reaches the RAM and is reported as an address error.
// Non-memory ops pass straight through to WB in one cycle.
//
// Ports
//   clk, rst                  clock; synchronous active-low reset
//   flush                     kill the op currently in MEM
//   mem_read_flag ..          op description from EX/MEM (mem ctrl, store data, ALU result,
//   current_pc_addr_in          writeback ctrl, PC)
//   ram_ready                 RAM accepts the request this cycle
//   ram_en .. ram_write_data  RAM request (combinational)
//   stall_req                 hold everything upstream of MEM/WB this cycle
//   *_out                     MEM/WB register contents, including single-cycle error flags

module mem_access_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        mem_read_flag,
   input  logic        mem_write_flag,
   input  logic        mem_sign_ext_flag,
   input  logic [3:0]  mem_sel,
   input  logic [31:0] mem_write_data,
   input  logic [31:0] result_in,
   input  logic        reg_write_en_in,
   input  logic [4:0]  reg_write_addr_in,
   input  logic [31:0] current_pc_addr_in,
   input  logic        ram_ready,
   output logic        ram_en,
   output logic [3:0]  ram_write_en,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_write_data,
   output logic        stall_req,
   output logic        mem_read_flag_out,
   output logic        mem_write_flag_out,
   output logic        mem_sign_ext_flag_out,
   output logic [3:0]  mem_sel_out,
   output logic [31:0] mem_write_data_out,
   output logic [31:0] result_out,
   output logic        reg_write_en_out,
   output logic [4:0]  reg_write_addr_out,
   output logic [31:0] current_pc_addr_out,
   output logic        addr_error_out,
   output logic        bus_error_out
);

   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [0:0] {StIdle, StWait} state_e;

   state_e          state;
   logic [CntW-1:0] wait_cnt;

   logic mem_op;
   logic sel_byte;
   logic sel_word;
   logic illegal;
   logic timeout;

   // RAM request and stall are combinational so an access accepted this cycle
   // is captured into MEM/WB at the same edge the RAM samples it.
   always_comb begin
      mem_op    = mem_read_flag | mem_write_flag;
      sel_byte  = (mem_sel == 4'b0001);
      sel_word  = (mem_sel == 4'b1111);
      illegal   = mem_op & ~(sel_byte | (sel_word & (result_in[1:0] == 2'b00)));
      timeout   = (state == StWait) & (wait_cnt == CntW'(TIMEOUT_CYCLES));
      ram_en    = rst & mem_op & ~illegal & ~flush & ~timeout;
      stall_req = ram_en & ~ram_ready;
      ram_addr  = {result_in[31:2], 2'b00};

      ram_write_en = 4'b0000;
      if (mem_write_flag) begin
         if (sel_word) begin
            ram_write_en = 4'b1111;
         end else if (sel_byte) begin
            ram_write_en = 4'b0001 << result_in[1:0];
         end
      end

      // Byte stores put the byte on every lane; the enables pick the right one.
      ram_write_data = sel_byte ? {4{mem_write_data[7:0]}} : mem_write_data;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state                 <= StIdle;
         wait_cnt              <= '0;
         mem_read_flag_out     <= 1'b0;
         mem_write_flag_out    <= 1'b0;
         mem_sign_ext_flag_out <= 1'b0;
         mem_sel_out           <= 4'b0000;
         mem_write_data_out    <= 32'h0;
         result_out            <= 32'h0;
         reg_write_en_out      <= 1'b0;
         reg_write_addr_out    <= 5'd0;
         current_pc_addr_out   <= 32'h0;
         addr_error_out        <= 1'b0;
         bus_error_out         <= 1'b0;
      end else begin
         // wait_cnt counts stalled cycles of the current request.
         unique case (state)
            StIdle: begin
               if (stall_req) begin
                  state    <= StWait;
                  wait_cnt <= CntW'(1);
               end
            end
            StWait: begin
               // Leaves on acceptance, flush or timeout (all drop stall_req).
               if (timeout || !stall_req) begin
                  state    <= StIdle;
                  wait_cnt <= '0;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
         endcase

         // Bubble by default; the cases below overwrite what they keep.
         mem_read_flag_out     <= 1'b0;
         mem_write_flag_out    <= 1'b0;
         mem_sign_ext_flag_out <= 1'b0;
         mem_sel_out           <= 4'b0000;
         mem_write_data_out    <= 32'h0;
         result_out            <= 32'h0;
         reg_write_en_out      <= 1'b0;
         reg_write_addr_out    <= 5'd0;
         current_pc_addr_out   <= 32'h0;
         addr_error_out        <= 1'b0;
         bus_error_out         <= 1'b0;

         if (!(flush || stall_req)) begin
            if (illegal) begin
               addr_error_out      <= 1'b1;
               result_out          <= result_in;
               current_pc_addr_out <= current_pc_addr_in;
            end else if (timeout) begin
               bus_error_out       <= 1'b1;
               current_pc_addr_out <= current_pc_addr_in;
            end else begin
               mem_read_flag_out     <= mem_read_flag;
               mem_write_flag_out    <= mem_write_flag;
               mem_sign_ext_flag_out <= mem_sign_ext_flag;
               mem_sel_out           <= mem_sel;
               mem_write_data_out    <= mem_write_data;
               result_out            <= result_in;
               reg_write_en_out      <= reg_write_en_in;
               reg_write_addr_out    <= reg_write_addr_in;
               current_pc_addr_out   <= current_pc_addr_in;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: table of single-cycle vectors, hand-written multi-cycle
// sequences (stall, timeout, reset and flush while waiting) and a randomized run checked
// against a model that counts consecutive stalled cycles of each request.

module tb_mem_access_unit;

   localparam int unsigned TO = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, flush, rd, wr, sx, rwe, ready;
   logic [3:0]  sel;
   logic [31:0] wd, res, pc;
   logic [4:0]  rwa;

   logic        ram_en, stall_req;
   logic [3:0]  ram_write_en;
   logic [31:0] ram_addr, ram_write_data;
   logic        mem_read_flag_out, mem_write_flag_out, mem_sign_ext_flag_out;
   logic [3:0]  mem_sel_out;
   logic [31:0] mem_write_data_out, result_out, current_pc_addr_out;
   logic        reg_write_en_out, addr_error_out, bus_error_out;
   logic [4:0]  reg_write_addr_out;

   mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
      .clk                   (clk),
      .rst                   (rst),
      .flush                 (flush),
      .mem_read_flag         (rd),
      .mem_write_flag        (wr),
      .mem_sign_ext_flag     (sx),
      .mem_sel               (sel),
      .mem_write_data        (wd),
      .result_in             (res),
      .reg_write_en_in       (rwe),
      .reg_write_addr_in     (rwa),
      .current_pc_addr_in    (pc),
      .ram_ready             (ready),
      .ram_en                (ram_en),
      .ram_write_en          (ram_write_en),
      .ram_addr              (ram_addr),
      .ram_write_data        (ram_write_data),
      .stall_req             (stall_req),
      .mem_read_flag_out     (mem_read_flag_out),
      .mem_write_flag_out    (mem_write_flag_out),
      .mem_sign_ext_flag_out (mem_sign_ext_flag_out),
      .mem_sel_out           (mem_sel_out),
      .mem_write_data_out    (mem_write_data_out),
      .result_out            (result_out),
      .reg_write_en_out      (reg_write_en_out),
      .reg_write_addr_out    (reg_write_addr_out),
      .current_pc_addr_out   (current_pc_addr_out),
      .addr_error_out        (addr_error_out),
      .bus_error_out         (bus_error_out)
   );

   typedef struct packed {
      logic        rd, wr, sx;
      logic [3:0]  sel;
      logic [31:0] wd, res;
      logic        rwe;
      logic [4:0]  rwa;
      logic [31:0] pc;
      logic        aerr, berr;
   } wb_t;

   wb_t dut_wb;
   assign dut_wb = {mem_read_flag_out, mem_write_flag_out, mem_sign_ext_flag_out, mem_sel_out,
                    mem_write_data_out, result_out, reg_write_en_out, reg_write_addr_out,
                    current_pc_addr_out, addr_error_out, bus_error_out};

   typedef struct {
      logic        rd, wr, sx;
      logic [3:0]  sel;
      logic [31:0] wd, addr;
      logic        e_en;
      logic [3:0]  e_we;
      logic [31:0] e_ra, e_wdata;
      logic        e_aerr;
   } vec_t;

   vec_t vecs[10];

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic r, input logic w, input logic s, input logic [3:0] sl,
                         input logic [31:0] d, input logic [31:0] a, input logic [31:0] p);
      rd = r; wr = w; sx = s; sel = sl; wd = d; res = a; pc = p; rwe = 1'b1; rwa = 5'd9;
   endtask

   // Counts stalled cycles until stall_req drops; leaves time just after inputs settle.
   task automatic count_stalls(output int n);
      n = 0;
      for (int k = 0; k < 40; k++) begin
         #1;
         if (!stall_req) break;
         n++;
         tick();
      end
   endtask

   // Reference model: cnt is the number of consecutive stalled cycles this request has seen.
   function automatic void model(input int cnt, output logic e_en, output logic e_stall,
                                 output logic [3:0] e_we, output logic [31:0] e_wd,
                                 output wb_t e_wb);
      logic mop, ill, to;
      mop  = rd | wr;
      ill  = mop && !((sel == 4'b0001) || (sel == 4'b1111 && res[1:0] == 2'b00));
      to   = (cnt == TO);
      e_en = rst && mop && !ill && !flush && !to;
      e_stall = e_en && !ready;
      if (!wr)                e_we = 4'b0000;
      else if (sel == 4'hf)   e_we = 4'b1111;
      else                    e_we = 4'(1 << res[1:0]);
      e_wd = (sel == 4'hf) ? wd : {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
      e_wb = '0;
      if (rst && !flush && !e_stall) begin
         if (ill) begin
            e_wb.aerr = 1'b1; e_wb.res = res; e_wb.pc = pc;
         end else if (to) begin
            e_wb.berr = 1'b1; e_wb.pc = pc;
         end else begin
            e_wb = {rd, wr, sx, sel, wd, res, rwe, rwa, pc, 1'b0, 1'b0};
         end
      end
   endfunction

   int          n;
   int          cnt;
   logic        prev_stall, stuck, e_en, e_stall;
   logic [3:0]  e_we;
   logic [31:0] e_wd;
   wb_t         e_wb;

   initial begin
      vecs[0] = '{1, 0, 1, 4'b0001, 32'h0,        32'h1003, 1, 4'b0000, 32'h1000, 32'h0,        0};
      vecs[1] = '{0, 1, 0, 4'b0001, 32'h12345678, 32'h2001, 1, 4'b0010, 32'h2000, 32'h78787878, 0};
      vecs[2] = '{0, 1, 0, 4'b1111, 32'hdeadbeef, 32'h4000, 1, 4'b1111, 32'h4000, 32'hdeadbeef, 0};
      vecs[3] = '{1, 0, 0, 4'b1111, 32'h0,        32'h3002, 0, 4'b0000, 32'h0,    32'h0,        1};
      vecs[4] = '{1, 0, 0, 4'b0011, 32'h0,        32'h5000, 0, 4'b0000, 32'h0,    32'h0,        1};
      vecs[5] = '{0, 0, 0, 4'b0000, 32'h0,        32'habcd, 0, 4'b0000, 32'h0,    32'h0,        0};
      vecs[6] = '{0, 1, 0, 4'b0001, 32'h000000aa, 32'h2003, 1, 4'b1000, 32'h2000, 32'haaaaaaaa, 0};
      vecs[7] = '{0, 1, 0, 4'b0000, 32'h55,       32'h2000, 0, 4'b0000, 32'h0,    32'h0,        1};
      vecs[8] = '{1, 0, 0, 4'b0001, 32'h0,        32'h3002, 1, 4'b0000, 32'h3000, 32'h0,        0};
      vecs[9] = '{0, 1, 0, 4'b1111, 32'h0,        32'h0002, 0, 4'b0000, 32'h0,    32'h0,        1};

      rst = 1'b0; flush = 1'b0; ready = 1'b1;
      set_op(0, 0, 0, 4'b0000, 32'h0, 32'h0, 32'h0);
      tick(); tick();
      check("reset_wb", dut_wb, '0);
      check("reset_ram_en", ram_en, 1'b0);
      check("reset_stall", stall_req, 1'b0);
      rst = 1'b1;

      // Single-cycle vectors, RAM always ready.
      for (int i = 0; i < 10; i++) begin
         set_op(vecs[i].rd, vecs[i].wr, vecs[i].sx, vecs[i].sel, vecs[i].wd, vecs[i].addr,
                32'h100 + i);
         ready = 1'b1;
         #1;
         check($sformatf("vec%0d_ram_en", i), ram_en, vecs[i].e_en);
         check($sformatf("vec%0d_stall", i), stall_req, 1'b0);
         if (vecs[i].e_en) begin
            check($sformatf("vec%0d_ram_addr", i), ram_addr, vecs[i].e_ra);
            check($sformatf("vec%0d_ram_we", i), ram_write_en, vecs[i].e_we);
            if (vecs[i].wr) check($sformatf("vec%0d_ram_wdata", i), ram_write_data,
                                  vecs[i].e_wdata);
         end
         tick();
         check($sformatf("vec%0d_aerr", i), addr_error_out, vecs[i].e_aerr);
         check($sformatf("vec%0d_result", i), result_out, vecs[i].addr);
         check($sformatf("vec%0d_pc", i), current_pc_addr_out, 32'h100 + i);
         check($sformatf("vec%0d_rwe", i), reg_write_en_out, !vecs[i].e_aerr);
         check($sformatf("vec%0d_sel", i), mem_sel_out, vecs[i].e_aerr ? 4'b0 : vecs[i].sel);
         check($sformatf("vec%0d_rd", i), mem_read_flag_out, vecs[i].e_aerr ? 1'b0 : vecs[i].rd);
      end

      // Word load, RAM busy for three cycles.
      set_op(1, 0, 0, 4'b1111, 32'h0, 32'h6000, 32'h600);
      ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         check($sformatf("busy_stall%0d", k), stall_req, 1'b1);
         tick();
         check($sformatf("busy_bubble%0d", k), dut_wb, '0);
      end
      ready = 1'b1;
      #1;
      check("busy_accept_stall", stall_req, 1'b0);
      check("busy_accept_en", ram_en, 1'b1);
      tick();
      check("busy_result", result_out, 32'h6000);
      check("busy_rd", mem_read_flag_out, 1'b1);
      check("busy_rwe", reg_write_en_out, 1'b1);

      // RAM never ready: timeout after TO stalled cycles.
      set_op(1, 0, 0, 4'b1111, 32'h0, 32'h7000, 32'h700);
      ready = 1'b0;
      count_stalls(n);
      check("to_stall_cycles", n, TO);
      check("to_ram_en", ram_en, 1'b0);
      tick();
      check("to_bus_err", bus_error_out, 1'b1);
      check("to_rwe", reg_write_en_out, 1'b0);
      check("to_pc", current_pc_addr_out, 32'h700);
      set_op(0, 0, 0, 4'b0000, 32'h0, 32'h42, 32'h704);
      tick();
      check("to_pulse_clear", bus_error_out, 1'b0);
      check("to_next_result", result_out, 32'h42);

      // Reset while waiting.
      set_op(1, 0, 0, 4'b1111, 32'h0, 32'h8000, 32'h800);
      ready = 1'b0;
      tick(); tick(); tick();
      rst = 1'b0;
      #1;
      check("rst_wait_ram_en", ram_en, 1'b0);
      check("rst_wait_stall", stall_req, 1'b0);
      tick();
      check("rst_wait_wb", dut_wb, '0);
      rst = 1'b1;
      count_stalls(n);
      check("rst_wait_restart", n, TO);
      tick();

      // Flush while waiting.
      set_op(0, 1, 0, 4'b1111, 32'h11223344, 32'h9000, 32'h900);
      ready = 1'b0;
      tick(); tick();
      flush = 1'b1;
      #1;
      check("flush_wait_ram_en", ram_en, 1'b0);
      check("flush_wait_stall", stall_req, 1'b0);
      tick();
      check("flush_wait_wb", dut_wb, '0);
      flush = 1'b0;
      count_stalls(n);
      check("flush_wait_restart", n, TO);
      tick();
      check("flush_wait_bus_err", bus_error_out, 1'b1);

      // Flush and ready together: flush wins.
      set_op(0, 1, 0, 4'b0001, 32'h99, 32'ha001, 32'ha00);
      ready = 1'b1; flush = 1'b1;
      #1;
      check("flush_ready_ram_en", ram_en, 1'b0);
      tick();
      check("flush_ready_wb", dut_wb, '0);
      flush = 1'b0;
      set_op(0, 0, 0, 4'b0000, 32'h0, 32'h0, 32'h0);
      tick();

      // Randomized run against the model.
      cnt = 0; prev_stall = 1'b0; stuck = 1'b0;
      for (int i = 0; i < 800; i++) begin
         rst   = ($urandom_range(0, 49) != 0);
         flush = ($urandom_range(0, 19) == 0);
         if (!prev_stall) begin
            {rd, wr} = 2'($urandom_range(0, 3));
            sx = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
               0, 1, 2: sel = 4'b0001;
               3, 4:    sel = 4'b1111;
               default: sel = 4'($urandom_range(0, 15));
            endcase
            wd  = $urandom;
            res = $urandom;
            if ($urandom_range(0, 1) == 0) res[1:0] = 2'b00;
            rwe = 1'($urandom_range(0, 1));
            rwa = 5'($urandom_range(0, 31));
            pc  = $urandom;
            stuck = ($urandom_range(0, 5) == 0);
         end
         ready = stuck ? 1'b0 : ($urandom_range(0, 2) != 0);
         #1;
         model(cnt, e_en, e_stall, e_we, e_wd, e_wb);
         check($sformatf("rnd%0d_ram_en", i), ram_en, e_en);
         check($sformatf("rnd%0d_stall", i), stall_req, e_stall);
         if (e_en) begin
            check($sformatf("rnd%0d_ram_addr", i), ram_addr, {res[31:2], 2'b00});
            check($sformatf("rnd%0d_ram_we", i), ram_write_en, e_we);
            if (wr) check($sformatf("rnd%0d_ram_wdata", i), ram_write_data, e_wd);
         end
         tick();
         check($sformatf("rnd%0d_wb", i), dut_wb, e_wb);
         cnt = e_stall ? cnt + 1 : 0;
         prev_stall = e_stall;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
